// File: rtl/run_ctrl.sv
// run_ctrl: run/step/halt execution controller for a small CPU core.
// Drives the execute enable (cpu_en), accepts RUN / STEP / HALT / CLRCNT
// commands, counts retired cycles and, when built with the macro
// RUN_CTRL_BKPT_EN, stops on a single PC breakpoint.
// Without RUN_CTRL_BKPT_EN the breakpoint inputs are ignored and bkpt_hit is 0.
module run_ctrl #(
  parameter int CNT_W  = 32,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_code,
  input  logic [STEP_W-1:0] cmd_arg,
  output logic              cmd_ready,
  input  logic [31:0]       pc,
  input  logic              bkpt_valid,
  input  logic [31:0]       bkpt_addr,
  output logic              cpu_en,
  output logic [1:0]        state,
  output logic              step_done,
  output logic              bkpt_hit,
  output logic [CNT_W-1:0]  retire_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_HALT = 2'b11
  } state_t;

  localparam logic [1:0] CMD_CLRCNT = 2'b00;
  localparam logic [1:0] CMD_RUN    = 2'b01;
  localparam logic [1:0] CMD_STEP   = 2'b10;
  localparam logic [1:0] CMD_HALT   = 2'b11;

  state_t             state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [CNT_W-1:0]   retire_q, retire_d;
  logic               done_q, done_d;

  logic cmd_acc;
  logic go_acc;      // accepted RUN or STEP: restarts execution
  logic active;
  logic bkpt_stop;

  assign cmd_ready = (state_q != S_STEP);
  assign cmd_acc   = cmd_valid && cmd_ready;
  assign go_acc    = cmd_acc && ((cmd_code == CMD_RUN) || (cmd_code == CMD_STEP));
  assign active    = (state_q == S_RUN) || (state_q == S_STEP);

`ifdef RUN_CTRL_BKPT_EN
  logic skip_q, skip_d;
  logic hit_q, hit_d;

  // The cycle right after a RUN/STEP acceptance ignores a match so the core
  // can step off the instruction it stopped on.
  assign bkpt_stop = active && bkpt_valid && (pc == bkpt_addr) && !skip_q;
  assign bkpt_hit  = hit_q;

  // Sticky hit flag: set by a stop, cleared by the next accepted RUN/STEP.
  always_comb begin
    hit_d  = hit_q;
    skip_d = go_acc;
    if (bkpt_stop) hit_d = 1'b1;
    if (go_acc)    hit_d = 1'b0;
  end

  // Breakpoint bookkeeping registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      hit_q  <= 1'b0;
      skip_q <= 1'b0;
    end else begin
      hit_q  <= hit_d;
      skip_q <= skip_d;
    end
  end
`else
  logic unused_bkpt;

  assign bkpt_stop   = 1'b0;
  assign bkpt_hit    = 1'b0;
  assign unused_bkpt = ^{bkpt_valid, bkpt_addr, pc};
`endif

  assign cpu_en     = active && !bkpt_stop;
  assign state      = state_q;
  assign step_done  = done_q;
  assign retire_cnt = retire_q;

  // Next-state, step countdown and retire counter.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    done_d   = 1'b0;
    retire_d = retire_q;

    if (cpu_en) retire_d = retire_q + CNT_W'(1);

    if ((state_q == S_STEP) && cpu_en) begin
      step_d = step_q - STEP_W'(1);
      if (step_q == STEP_W'(1)) begin
        state_d = S_HALT;
        done_d  = 1'b1;
      end
    end

    if (bkpt_stop) state_d = S_HALT;

    if (cmd_acc) begin
      case (cmd_code)
        CMD_CLRCNT: retire_d = '0;
        CMD_RUN:    state_d  = S_RUN;
        CMD_STEP: begin
          state_d = S_STEP;
          step_d  = (cmd_arg == '0) ? STEP_W'(1) : cmd_arg;
        end
        CMD_HALT:   state_d  = S_HALT;
        default:    state_d  = state_q;
      endcase
    end
  end

  // State and counter registers; reset aborts any run or step in progress.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      retire_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      retire_q <= retire_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, giving the width of the retire counter.
REQ-002 The block SHALL have parameter STEP_W, default 8, giving the width of the step-count argument.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port clr, input, 1, the reset: asynchronous, active-low (0 = reset).
REQ-005 The block SHALL have port cmd_valid, input, 1, meaning a command is presented.
REQ-006 The block SHALL have port cmd_code, input, 2, the command: 00 CLRCNT, 01 RUN, 10 STEP, 11 HALT.
REQ-007 The block SHALL have port cmd_arg, input, STEP_W, the step count for STEP; ignored for other codes.
REQ-008 The block SHALL have port cmd_ready, output, 1, meaning a command is accepted on this edge when cmd_valid=1.
REQ-009 The block SHALL have port pc, input, 32, the current CPU program counter.
REQ-010 The block SHALL have port bkpt_valid, input, 1, the breakpoint enable.
REQ-011 The block SHALL have port bkpt_addr, input, 32, the breakpoint PC.
REQ-012 The block SHALL have port cpu_en, output, 1, the execute enable gating PC update, register-file write and data-memory write.
REQ-013 The block SHALL have port state, output, 2, the FSM state: 00 IDLE, 01 RUN, 10 STEP, 11 HALT.
REQ-014 The block SHALL have port step_done, output, 1, a one-cycle pulse when a STEP sequence completes.
REQ-015 The block SHALL have port bkpt_hit, output, 1, a sticky breakpoint-stop flag.
REQ-016 The block SHALL have port retire_cnt, output, CNT_W, the count of cycles with cpu_en=1.

Function
REQ-017 The block SHALL accept a command on a rising edge where cmd_valid=1 and cmd_ready=1; the new state takes effect from the next cycle.
REQ-018 The block SHALL drive cmd_ready=1 in IDLE, RUN and HALT, and cmd_ready=0 in STEP; commands are not accepted during STEP.
REQ-019 The block SHALL, on RUN accepted from IDLE, HALT or RUN, enter or stay in RUN; RUN in RUN has no other effect.
REQ-020 The block SHALL, on STEP accepted, enter STEP and load the step counter with cmd_arg, where cmd_arg=0 is treated as 1.
REQ-021 The block SHALL, on HALT accepted, enter HALT from any state; HALT in IDLE also goes to HALT.
REQ-022 The block SHALL, on CLRCNT accepted, clear retire_cnt to 0 on that edge without changing state; the clear takes priority over the increment in the same cycle.
REQ-023 The block SHALL drive cpu_en combinationally as 1 in RUN or STEP unless a breakpoint stop applies that cycle (REQ-031), and 0 in IDLE or HALT.
REQ-024 The block SHALL, in STEP, keep cpu_en=1 for exactly N consecutive cycles, decrement the step counter on each enabled cycle, and enter HALT after the Nth.
REQ-025 The block SHALL assert step_done for one cycle: the first cycle in HALT after a STEP completes normally.
REQ-026 The block SHALL not assert step_done when a STEP is ended by a breakpoint.
REQ-027 The block SHALL increment retire_cnt by 1 on each edge where cpu_en=1.
REQ-028 The block SHALL wrap retire_cnt from 2^CNT_W-1 to 0 with no flag.

Reset
REQ-029 The block SHALL, while clr=0, immediately force state=IDLE, cpu_en=0, cmd_ready=1, step_done=0, bkpt_hit=0, retire_cnt=0, step counter=0.
REQ-030 The block SHALL abort any RUN or STEP in progress when clr is asserted, with no step_done; after release it waits in IDLE for a command.

Configuration
REQ-031 With macro RUN_CTRL_BKPT_EN defined, the breakpoint SHALL operate as follows.
  Match: in RUN or STEP, bkpt_valid=1 and pc==bkpt_addr.
  Effect: cpu_en=0 that cycle, so the instruction is not executed; state goes to HALT; bkpt_hit is set.
  Skip: a match is ignored in the first cycle after any RUN or STEP acceptance, to allow stepping off a breakpoint.
  Clear: bkpt_hit clears on the next accepted RUN or STEP.
  Simultaneous: a HALT command in the same cycle as a match gives HALT with bkpt_hit=1.
REQ-032 Without RUN_CTRL_BKPT_EN, bkpt_valid and bkpt_addr SHALL be ignored and bkpt_hit tied to 0; the port list is unchanged.

Verification
REQ-033 Reset, then RUN; after 10 cycles, HALT -> cpu_en=0 before RUN acceptance, retire_cnt=10, then state=HALT.
REQ-034 From HALT, STEP with cmd_arg=3 -> cpu_en=1 for exactly 3 cycles; cmd_ready=0 throughout; step_done pulses once; state=HALT; retire_cnt +3.
REQ-035 STEP with cmd_arg=0 -> exactly 1 enabled cycle, then step_done pulses.
REQ-036 With BKPT_EN, bkpt_addr=0x10, RUN from pc=0x00 -> cpu_en=0 when pc=0x10; state=HALT; bkpt_hit=1; next RUN executes 0x10 (skip rule) and clears bkpt_hit.
REQ-037 With CNT_W=4, RUN 17 cycles -> retire_cnt=1; CLRCNT while running -> 0 on that edge, then increments from 1.
REQ-038 Assert clr mid-STEP (cmd_arg=5, after 2 cycles) -> immediately state=IDLE, cpu_en=0, no step_done, retire_cnt=0.
